// File: rtl/pio_override_arb.sv
// pio_override_arb: round-robin PIO command injector in front of the RTL master.
// Channels own the bus for one write or one read+response; RTL drops are counted.
module pio_override_arb #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int NUM_CH     = 2,
  parameter int RD_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_cmd_vld,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_data_w,
  input  logic [NUM_CH-1:0]        ch_rw,
  output logic [NUM_CH-1:0]        ch_gnt,
  output logic [NUM_CH-1:0]        ch_rd_vld,
  output logic [NUM_CH-1:0]        ch_rd_timeout,
  output logic [DATA_W-1:0]        ch_data_r,
  input  logic                     rtl_cmd_vld,
  input  logic [ADDR_W-1:0]        rtl_addr,
  input  logic [DATA_W-1:0]        rtl_data_w,
  input  logic                     rtl_rw,
  output logic                     cmd_vld,
  output logic [ADDR_W-1:0]        addr,
  output logic [DATA_W-1:0]        data_w,
  output logic                     rw,
  input  logic [DATA_W-1:0]        data_r,
  input  logic                     rd_vld,
  output logic                     override,
  output logic [7:0]               rtl_drop_cnt
);

  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TCNT_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [IDX_W:0]    NCH   = (IDX_W+1)'(NUM_CH);
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(NUM_CH - 1);
  localparam logic [TCNT_W-1:0] TLAST = TCNT_W'(RD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  win;
  logic [IDX_W-1:0]  win_inc;
  logic [IDX_W:0]    j;
  logic              found;
  logic              grant;
  logic              drop;
  logic [TCNT_W-1:0] tcnt;

  // Rotating search: first requester at or after rr_ptr, wrapping to 0
  always_comb begin
    win   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      j = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (j >= NCH) j = j - NCH;
      if (!found && ch_cmd_vld[j[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = j[IDX_W-1:0];
      end
    end
  end

  assign grant   = reset && (state == IDLE) && found;
  assign win_inc = (win == LAST) ? '0 : win + 1'b1;
  assign drop    = rtl_cmd_vld && (grant || state != IDLE);

  always_comb begin
    ch_gnt = '0;
    if (grant) ch_gnt[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (found) state_nxt = ISSUE;
      ISSUE:   state_nxt = rw ? WAIT_RD : IDLE;
      WAIT_RD: if (rd_vld || tcnt == TLAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cmd_vld       <= 1'b0;
      addr          <= '0;
      data_w        <= '0;
      rw            <= 1'b0;
      override      <= 1'b0;
      owner         <= '0;
      rr_ptr        <= '0;
      tcnt          <= '0;
      ch_rd_vld     <= '0;
      ch_rd_timeout <= '0;
      ch_data_r     <= '0;
      rtl_drop_cnt  <= '0;
    end else begin
      cmd_vld       <= 1'b0;
      ch_rd_vld     <= '0;
      ch_rd_timeout <= '0;
      override      <= (state_nxt != IDLE);
      if (drop && rtl_drop_cnt != 8'hFF)
        rtl_drop_cnt <= rtl_drop_cnt + 8'd1;
      unique case (state)
        IDLE: begin
          if (grant) begin
            cmd_vld <= 1'b1;
            addr    <= ch_addr[win*ADDR_W +: ADDR_W];
            data_w  <= ch_data_w[win*DATA_W +: DATA_W];
            rw      <= ch_rw[win];
            owner   <= win;
            rr_ptr  <= win_inc;
          end else begin
            cmd_vld <= rtl_cmd_vld;
            addr    <= rtl_addr;
            data_w  <= rtl_data_w;
            rw      <= rtl_rw;
          end
        end
        ISSUE: tcnt <= '0;
        WAIT_RD: begin
          // a response in the final count cycle wins over the timeout
          if (rd_vld) begin
            ch_data_r        <= data_r;
            ch_rd_vld[owner] <= 1'b1;
          end else if (tcnt == TLAST) begin
            ch_data_r            <= '1;
            ch_rd_timeout[owner] <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/pio_override_arb.md
# pio_override_arb

Parametrised PIO command injector that sits between the RTL's PIO master and the PIO bus. NUM_CH testbench or debug channels can take the bus over from the RTL for one complete command: a write, or a read together with its response. The block round-robin arbitrates among the channels, routes each read response (or a timeout) back to the owning channel, and counts RTL commands it drops while it owns the bus. It generalises the fixed 16/32-bit single-channel override to any address/data width and channel count, and adds read tracking.

## Interface
Parameters:
- ADDR_W, 16, address width
- DATA_W, 32, data width
- NUM_CH, 2, injecting channels (≥1)
- RD_TIMEOUT, 16, cycles to wait for rd_vld before timing out (≥1)

Ports:
- clk  input  1  the block's only clock
- reset  input  1  synchronous, active-low reset
- ch_cmd_vld  input  NUM_CH  per-channel command request, held until granted
- ch_addr  input  NUM_CH*ADDR_W  packed; channel i at [i*ADDR_W +: ADDR_W]
- ch_data_w  input  NUM_CH*DATA_W  packed write data
- ch_rw  input  NUM_CH  1 = read, 0 = write
- ch_gnt  output  NUM_CH  one-hot accept pulse; combinational
- ch_rd_vld  output  NUM_CH  read-response pulse to the owning channel
- ch_rd_timeout  output  NUM_CH  read-timeout pulse to the owning channel
- ch_data_r  output  DATA_W  read data, shared by all channels, qualified by ch_rd_vld
- rtl_cmd_vld, rtl_addr, rtl_data_w, rtl_rw  input  1/ADDR_W/DATA_W/1  RTL master command
- cmd_vld, addr, data_w, rw  output  1/ADDR_W/DATA_W/1  registered PIO bus command
- data_r  input  DATA_W  bus read data
- rd_vld  input  1  bus read-response strobe
- override  output  1  high while the block owns the bus
- rtl_drop_cnt  output  8  saturating count of dropped RTL commands

## Operation
- FSM states: IDLE, ISSUE, WAIT_RD.
- **IDLE.** If any ch_cmd_vld bit is set, the round-robin winner w gets ch_gnt[w]=1. At the next edge:
  - the bus registers load w's command with cmd_vld=1;
  - the FSM moves to ISSUE;
  - rr_ptr is set to w+1 (mod NUM_CH).
- **IDLE, no request.** The bus registers load the rtl_* inputs, i.e. one-cycle pass-through.
- **ISSUE.** cmd_vld is 0 in the next cycle; addr, data_w and rw hold.
  - For a write, the FSM returns to IDLE.
  - For a read, it goes to WAIT_RD with tcnt=0.
- **WAIT_RD.**
  - If rd_vld=1: ch_data_r<=data_r, ch_rd_vld[w]=1 for one cycle, FSM to IDLE.
  - Else if tcnt==RD_TIMEOUT-1: ch_rd_timeout[w]=1 for one cycle, ch_data_r<=all-ones, FSM to IDLE.
  - Otherwise tcnt increments.
  - rd_vld in the final count cycle counts as a response, not a timeout.
- **override.** Registered; equals 1 exactly in the ISSUE and WAIT_RD cycles.
- **Dropped RTL commands.**
  - An RTL command is dropped if rtl_cmd_vld=1 in a cycle where a grant occurs, or in any ISSUE or WAIT_RD cycle.
  - Each drop increments rtl_drop_cnt, which saturates at 255.
  - Dropped commands never appear on the bus.
- **Stray rd_vld.** rd_vld outside WAIT_RD, including in the ISSUE cycle, is ignored by the channel side.
- **Round robin.** Search starts at rr_ptr and takes the lowest index ≥ rr_ptr with a request, wrapping to 0. At most one ch_gnt bit is set.
- **Widths.** tcnt is $clog2(RD_TIMEOUT+1) bits. rtl_drop_cnt is 8 bits, saturating.

## Timing
- **Reset (reset=0 at a clock edge).** All outputs 0, state IDLE, rr_ptr=0, tcnt=0, rtl_drop_cnt=0.
- **Reset mid-read.** Reset during ISSUE or WAIT_RD abandons the command; no ch_rd_vld or ch_rd_timeout pulse is issued.
- **Grant.** Grant in cycle T gives bus cmd_vld=1 and override=1 in T+1. The channel deasserts or changes its request from T+1.
- **Read.** WAIT_RD spans T+2 to T+1+RD_TIMEOUT.
  - A response sampled in cycle k produces ch_rd_vld in k+1.
  - With no response, ch_rd_timeout appears in T+2+RD_TIMEOUT.
- **Back-to-back.** A new grant may occur in the same cycle as a ch_rd_vld or ch_rd_timeout pulse, because the FSM is already in IDLE.
- **RTL path.** Pass-through latency is exactly 1 cycle whenever no override is in progress.
- **Write throughput.** Writes run at most one per 2 cycles (grant, ISSUE).

## Test plan
- **Reset and pass-through.** Hold reset=0 for 3 cycles, check all outputs 0. Release, drive rtl write addr=0x1234 data=0xDEADBEEF. Expect the bus to show it one cycle later with override=0.
- **Channel write with collision.**
  - Stimulus: ch0 write addr=0x0010 data=0xA5A5A5A5, with rtl_cmd_vld=1 in the same cycle.
  - Expect ch_gnt=01, then a bus write cmd_vld=1 for 1 cycle.
  - Expect rtl_drop_cnt=1 and the RTL command never on the bus.
- **Channel read with response.** ch1 read addr=0x0020; slave returns rd_vld with data_r=0x12345678 3 cycles after cmd_vld. Expect ch_rd_vld=10 and ch_data_r=0x12345678 one cycle later, override low afterwards.
- **Read timeout.**
  - With RD_TIMEOUT=4, ch0 issues a read and no rd_vld arrives.
  - Expect ch_rd_timeout[0] exactly 6 cycles after grant, ch_data_r=0xFFFFFFFF.
  - Repeat with rd_vld on the last WAIT_RD cycle: expect a response, not a timeout.
- **Round-robin fairness.** With NUM_CH=3, all channels hold write requests continuously. Expect grants 0,1,2,0,1,2 spaced 2 cycles apart.
- **Mid-read reset and saturation.**
  - Assert reset during WAIT_RD: expect no response pulse and IDLE afterwards.
  - Separately, drive 300 RTL commands during overrides: expect rtl_drop_cnt=255.
